// File: rtl/seq_det_ctrl.sv
// Sequencing controller for a Moore "1011" serial detector: loads a word, shifts it MSB-first, counts hits.
// Optional first-hit position/any-hit outputs are enabled by defining SEQ_DET_CTRL_FIRST_POS_EN.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// CLEAR | detector held in clear for one cycle
// SHIFT | W cycles driving det_in from the shift register MSB
// DRAIN | det_in low, last hit sample taken
// DONE  | one-cycle done pulse, hit_count final
module seq_det_ctrl #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          det_clr,
   output logic          det_in,
   input  logic          det_hit,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] hit_count
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
   ,
   output logic [$clog2(W)-1:0] first_hit_pos,
   output logic                 hit_any
`endif
);

   localparam int IW = $clog2(W);

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

   state_t         state;
   logic [W-1:0]   sr;
   logic [IW-1:0]  idx;
   logic           take_sample;

   // The detector output lags det_in by one cycle, so bit i is seen in SHIFT i+1 or DRAIN.
   always_comb begin
      take_sample = det_hit && (((state == SHIFT) && (idx != '0)) || (state == DRAIN));
   end

`ifdef SEQ_DET_CTRL_FIRST_POS_EN
   logic [IW-1:0] credit_pos;
   always_comb begin
      credit_pos = (state == DRAIN) ? IW'(W - 1) : idx - 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sr        <= '0;
         idx       <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         det_clr   <= 1'b0;
         det_in    <= 1'b0;
         hit_count <= '0;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
         first_hit_pos <= '0;
         hit_any       <= 1'b0;
`endif
      end else begin
         if (take_sample) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
            if (!hit_any) begin
               first_hit_pos <= credit_pos;
               hit_any       <= 1'b1;
            end
`endif
         end
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sr        <= in_data;
                  idx       <= '0;
                  hit_count <= '0;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
                  first_hit_pos <= '0;
                  hit_any       <= 1'b0;
`endif
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  det_clr   <= 1'b1;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               det_clr <= 1'b0;
               det_in  <= sr[W-1];
               sr      <= {sr[W-2:0], 1'b0};
               state   <= SHIFT;
            end
            SHIFT: begin
               if (idx == IW'(W - 1)) begin
                  det_in <= 1'b0;
                  state  <= DRAIN;
               end else begin
                  det_in <= sr[W-1];
                  sr     <= {sr[W-2:0], 1'b0};
                  idx    <= idx + 1'b1;
               end
            end
            DRAIN: begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done     <= 1'b0;
               in_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (W=8/CW=4 and W=16/CW=2), each with a "1011" detector model
// and a per-cycle reference model, plus directed words with hand-computed results.
module tb_seq_det_ctrl;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        vld_v = '0;
   logic [1:0][15:0]  dat_v = '0;
   wire  [1:0]        rdy_v, bsy_v, done_v, din_v;
   wire  [1:0][15:0]  hc_v;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
   wire  [1:0][3:0]   fhp_v;
   wire  [1:0]        any_v;
`endif
   bit                started = 1'b0;
   int                nvec = 0;
   int                nerr = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int W  = (g == 1) ? 16 : 8;
      localparam int CW = (g == 1) ? 2 : 4;

      logic          in_ready, det_clr, det_in, det_hit, busy, done;
      logic [CW-1:0] hit_count;
      logic [3:0]    hist = '0;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
      logic [$clog2(W)-1:0] first_hit_pos;
      logic                 hit_any;
`endif

      seq_det_ctrl #(.W(W), .CW(CW)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (vld_v[g]),
         .in_ready  (in_ready),
         .in_data   (dat_v[g][W-1:0]),
         .det_clr   (det_clr),
         .det_in    (det_in),
         .det_hit   (det_hit),
         .busy      (busy),
         .done      (done),
         .hit_count (hit_count)
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
         ,
         .first_hit_pos (first_hit_pos),
         .hit_any       (hit_any)
`endif
      );

      // Detector: last four bits seen, Moore output asserted when they read 1011.
      always @(posedge clk) hist <= det_clr ? 4'b0000 : {hist[2:0], det_in};
      assign det_hit = (hist == 4'b1011);

      assign rdy_v[g]  = in_ready;
      assign bsy_v[g]  = busy;
      assign done_v[g] = done;
      assign din_v[g]  = det_in;
      assign hc_v[g]   = 16'(hit_count);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
      assign fhp_v[g]  = 4'(first_hit_pos);
      assign any_v[g]  = hit_any;
`endif

      // Reference: k counts cycles since acceptance (1 = clear cycle), credited = bits whose hit is counted.
      int           k = 0;
      int           credited = 0;
      logic [W-1:0] mw = '0;

      function automatic bit hit_at(input logic [W-1:0] w, input int j);
         return w[W+2-j] && !w[W+1-j] && w[W-j] && w[W-1-j];
      endfunction

      function automatic int hits_before(input logic [W-1:0] w, input int n);
         int c = 0;
         for (int j = 3; j < n; j++) if (hit_at(w, j)) c++;
         return c;
      endfunction

      function automatic int first_pos(input logic [W-1:0] w, input int n);
         for (int j = 3; j < n; j++) if (hit_at(w, j)) return j;
         return 0;
      endfunction

      function automatic int sat(input int c);
         return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
      endfunction

      always @(posedge clk) begin
         if (rst) begin
            k        <= 0;
            credited <= 0;
            mw       <= '0;
         end else if (k == 0) begin
            if (vld_v[g]) begin
               k        <= 1;
               credited <= 0;
               mw       <= dat_v[g][W-1:0];
            end
         end else if (k == W + 3) begin
            k <= 0;
         end else begin
            k <= k + 1;
            if (k + 1 >= 4) credited <= k - 2;
         end
      end

      always @(negedge clk) begin
         if (started) begin
            chk($sformatf("u%0d in_ready", g), int'(in_ready), int'(k == 0));
            chk($sformatf("u%0d busy", g), int'(busy), int'(k != 0));
            chk($sformatf("u%0d det_clr", g), int'(det_clr), int'(k == 1));
            chk($sformatf("u%0d det_in k=%0d", g, k), int'(det_in),
                (k >= 2 && k <= W + 1) ? int'(mw[W+1-k]) : 0);
            chk($sformatf("u%0d done", g), int'(done), int'(k == W + 3));
            chk($sformatf("u%0d hit_count k=%0d", g, k), int'(hit_count), sat(hits_before(mw, credited)));
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
            chk($sformatf("u%0d hit_any", g), int'(hit_any), int'(hits_before(mw, credited) > 0));
            chk($sformatf("u%0d first_hit_pos", g), int'(first_hit_pos), first_pos(mw, credited));
`endif
         end
      end
   end

   task automatic offer(input int g, input logic [15:0] w, output int waited);
      bit ok = 1'b0;
      dat_v[g] = w;
      vld_v[g] = 1'b1;
      waited   = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         waited++;
         if (rdy_v[g]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk($sformatf("u%0d offer accepted", g), 0, 1);
      @(posedge clk);
      #1 vld_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int exp_lat, input int exp_hc,
                            input logic [15:0] exp_seq, input int nbits);
      logic [15:0] seq = '0;
      int          c = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= nbits + 1) seq = {seq[14:0], din_v[g]};
         if (done_v[g]) begin
            c = i;
            break;
         end
      end
      chk($sformatf("u%0d done latency", g), c, exp_lat);
      chk($sformatf("u%0d final hit_count", g), int'(hc_v[g]), exp_hc);
      chk($sformatf("u%0d det_in sequence", g), int'(seq), int'(exp_seq));
   endtask

   initial begin
      int waited;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;
      @(negedge clk);
      chk("reset in_ready", int'(rdy_v[0]), 1);
      chk("reset busy", int'(bsy_v[0]), 0);
      chk("reset done", int'(done_v[0]), 0);
      chk("reset hit_count", int'(hc_v[0]), 0);

      offer(0, 16'h00B0, waited);
      wait_done(0, 11, 1, 16'h00B0, 8);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
      chk("B0 first_hit_pos", int'(fhp_v[0]), 3);
      chk("B0 hit_any", int'(any_v[0]), 1);
`endif

      offer(0, 16'h0000, waited);
      wait_done(0, 11, 0, 16'h0000, 8);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
      chk("00 hit_any", int'(any_v[0]), 0);
`endif

      offer(0, 16'h00AB, waited);
      wait_done(0, 11, 1, 16'h00AB, 8);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
      chk("AB first_hit_pos", int'(fhp_v[0]), 7);
`endif

      // Second word held on the handshake for the whole first scan.
      offer(0, 16'h00BB, waited);
      dat_v[0] = 16'h002D;
      vld_v[0] = 1'b1;
      wait_done(0, 11, 2, 16'h00BB, 8);
      offer(0, 16'h002D, waited);
      chk("backpressure accept gap", waited, 1);
      wait_done(0, 11, 1, 16'h002D, 8);

      // Reset sampled at the edge that ends SHIFT i=4.
      offer(0, 16'h00BB, waited);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midscan rst hit_count", int'(hc_v[0]), 0);
      chk("midscan rst in_ready", int'(rdy_v[0]), 1);
      chk("midscan rst done", int'(done_v[0]), 0);
      chk("midscan rst busy", int'(bsy_v[0]), 0);
      offer(0, 16'h00B0, waited);
      wait_done(0, 11, 1, 16'h00B0, 8);

      offer(1, 16'hB6DB, waited);
      wait_done(1, 19, 3, 16'hB6DB, 16);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
